// File: rtl/top2_clap_light_if.sv
// SPI link between the clap-light master and the microphone ADC.
// The master drives clock and chip select; the ADC returns serial data.
interface top2_clap_light_if;
    logic spi_clock;
    logic spi_chipselect;
    logic spi_data;

    modport master (
        output spi_clock,
        output spi_chipselect,
        input  spi_data
    );

    modport slave (
        input  spi_clock,
        input  spi_chipselect,
        output spi_data
    );
endinterface

// File: rtl/top2_clap_light.sv
// Clap-clap light: SPI sample reader, windowed energy and double-clap
// detector that toggles the light output.
module top2_clap_light #(
    parameter int              SAMPLE_WIDTH     = 16,
    parameter int              SPI_DIV          = 2,
    parameter int              CS_IDLE          = 4,
    parameter int              WIN_LOG2         = 4,
    parameter longint unsigned ENERGY_THRESHOLD = 64'd1 << 30,
    parameter int              GAP_MAX          = 8
) (
    input  logic              clock,
    input  logic              nreset,
    top2_clap_light_if.master spi,
    output logic              toglite_state
);
    localparam int SW   = SAMPLE_WIDTH;
    localparam int EW   = 2 * SW + WIN_LOG2;
    localparam int CMAX = (CS_IDLE > 2 * SPI_DIV) ? CS_IDLE : 2 * SPI_DIV;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(SW);
    localparam int GW   = $clog2(GAP_MAX + 2);
    localparam logic [EW-1:0] THR = EW'(ENERGY_THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT,
        S_DESELECT
    } spi_state_t;

    typedef enum logic {
        WAIT_FIRST,
        WAIT_SECOND
    } det_state_t;

    spi_state_t       spi_state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;
    logic [SW-1:0]    shift_reg;
    logic             cs_q;
    logic             sclk_q;
    logic             sample_valid;

    logic [EW-1:0]       acc;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [EW-1:0]       energy_reg;
    logic                energy_ready_sig;

    det_state_t    det_state;
    logic [GW-1:0] gap;
    logic          loud_prev;

    logic signed [2*SW-1:0] sample_ext;
    logic [2*SW-1:0]        square;
    logic                   loud;
    logic                   clap;

    assign spi.spi_clock      = sclk_q;
    assign spi.spi_chipselect = cs_q;

    // Sign-extend first so full-scale negative squares cleanly to 2^30.
    assign sample_ext = {{SW{shift_reg[SW-1]}}, shift_reg};
    assign square     = sample_ext * sample_ext;

    assign loud = (energy_reg >= THR);
    assign clap = loud & ~loud_prev;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            spi_state    <= S_IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (spi_state)
                S_IDLE: begin
                    if (cnt == CW'(CS_IDLE - 1)) begin
                        spi_state <= S_SELECT;
                        cs_q      <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SELECT: begin
                    if (cnt == CW'(SPI_DIV - 1)) begin
                        spi_state <= S_SHIFT;
                        sclk_q    <= 1'b0;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Low half ends: raise the clock and capture the bit.
                    if (cnt == CW'(SPI_DIV - 1)) begin
                        sclk_q    <= 1'b1;
                        shift_reg <= {shift_reg[SW-2:0], spi.spi_data};
                    end
                    if (cnt == CW'(2 * SPI_DIV - 1)) begin
                        cnt <= '0;
                        if (bit_cnt == BW'(SW - 1)) begin
                            spi_state <= S_DESELECT;
                        end else begin
                            sclk_q  <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DESELECT: begin
                    if (cnt == CW'(SPI_DIV - 1)) begin
                        spi_state    <= S_IDLE;
                        cs_q         <= 1'b1;
                        sample_valid <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: spi_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc              <= '0;
            win_cnt          <= '0;
            energy_reg       <= '0;
            energy_ready_sig <= 1'b0;
        end else begin
            energy_ready_sig <= 1'b0;
            if (sample_valid) begin
                win_cnt <= win_cnt + 1'b1;
                if (win_cnt == '1) begin
                    energy_reg       <= acc + EW'(square);
                    acc              <= '0;
                    energy_ready_sig <= 1'b1;
                end else begin
                    acc <= acc + EW'(square);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            det_state     <= WAIT_FIRST;
            gap           <= '0;
            loud_prev     <= 1'b0;
            toglite_state <= 1'b0;
        end else if (energy_ready_sig) begin
            loud_prev <= loud;
            unique case (det_state)
                WAIT_FIRST: begin
                    if (clap) begin
                        det_state <= WAIT_SECOND;
                        gap       <= '0;
                    end
                end
                WAIT_SECOND: begin
                    if (clap && gap != '0 && gap <= GW'(GAP_MAX)) begin
                        toglite_state <= ~toglite_state;
                        det_state     <= WAIT_FIRST;
                    end else begin
                        gap <= gap + 1'b1;
                        if (gap >= GW'(GAP_MAX)) begin
                            det_state <= WAIT_FIRST;
                        end
                    end
                end
                default: det_state <= WAIT_FIRST;
            endcase
        end
    end
endmodule

// File: tb/tb_top2_clap_light.sv
// Bench for the clap-clap light: SPI ADC model feeding sample words and
// a window-level reference model of energy, claps and light state.
module tb_top2_clap_light;
    logic clock = 1'b0;
    logic nreset;
    logic toglite_state;

    top2_clap_light_if spi();

    top2_clap_light dut (
        .clock         (clock),
        .nreset        (nreset),
        .spi           (spi),
        .toglite_state (toglite_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] tx_q[$];
    logic [15:0] mdl_q[$];

    bit m_pend;
    int m_pend_idx;
    bit m_prev_loud;
    bit m_light;
    int m_win;

    // ADC model: new bit after each falling spi_clock, MSB first.
    initial begin
        logic [15:0] cur;
        spi.spi_data = 1'b0;
        forever begin
            @(negedge spi.spi_chipselect);
            cur = (tx_q.size() > 0) ? tx_q.pop_front() : 16'h0000;
            for (int b = 15; b >= 0; b--) begin
                @(negedge spi.spi_clock or posedge spi.spi_chipselect);
                if (spi.spi_chipselect) break;
                spi.spi_data = cur[b];
            end
        end
    end

    initial begin
        #(950000);
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [35:0] sq(input logic [15:0] v);
        longint s;
        s = longint'($signed(v));
        return 36'(s * s);
    endfunction

    task automatic do_reset();
        nreset = 1'b0;
        tx_q.delete();
        mdl_q.delete();
        m_pend      = 1'b0;
        m_pend_idx  = 0;
        m_prev_loud = 1'b0;
        m_light     = 1'b0;
        m_win       = 0;
        repeat (3) @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic push(input logic [15:0] v, input int n);
        repeat (n) begin
            tx_q.push_back(v);
            mdl_q.push_back(v);
        end
    endtask

    // Reference: per window, energy = sum of squares; a clap is a
    // quiet->loud window; two claps with 1..8 windows between toggle.
    task automatic step_windows(input int n, input string tag);
        logic [35:0] e;
        bit loud;
        bit clap;
        bit got;
        int between;
        for (int w = 0; w < n; w++) begin
            e = '0;
            for (int i = 0; i < 16; i++) e += sq(mdl_q.pop_front());
            loud = (e >= 36'h0_4000_0000);
            clap = loud && !m_prev_loud;
            m_prev_loud = loud;
            between = m_win - m_pend_idx - 1;
            if (clap) begin
                if (m_pend && between >= 1 && between <= 8) begin
                    m_light = !m_light;
                    m_pend  = 1'b0;
                end else begin
                    m_pend     = 1'b1;
                    m_pend_idx = m_win;
                end
            end
            m_win++;
            got = 1'b0;
            for (int c = 0; c < 16 * 80 && !got; c++) begin
                @(negedge clock);
                if (dut.energy_ready_sig === 1'b1) got = 1'b1;
            end
            n_checks++;
            if (got !== 1'b1) begin
                n_errors++;
                $display("FAIL %s w%0d ready got timeout want pulse",
                         tag, w);
            end
            n_checks++;
            if (dut.energy_reg !== e) begin
                n_errors++;
                $display("FAIL %s w%0d energy got %h want %h",
                         tag, w, dut.energy_reg, e);
            end
            @(negedge clock);
            n_checks++;
            if (toglite_state !== m_light) begin
                n_errors++;
                $display("FAIL %s w%0d light got %b want %b",
                         tag, w, toglite_state, m_light);
            end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (spi.spi_chipselect !== 1'b1) begin
            n_errors++;
            $display("FAIL reset cs got %b want 1", spi.spi_chipselect);
        end
        n_checks++;
        if (spi.spi_clock !== 1'b1) begin
            n_errors++;
            $display("FAIL reset sclk got %b want 1", spi.spi_clock);
        end
        n_checks++;
        if (toglite_state !== 1'b0) begin
            n_errors++;
            $display("FAIL reset light got %b want 0", toglite_state);
        end
        n_checks++;
        if (dut.energy_reg !== 36'h0) begin
            n_errors++;
            $display("FAIL reset energy got %h want 0", dut.energy_reg);
        end
    endtask

    task automatic test_frame_timing();
        int c;
        int d;
        int e;
        int falls;
        int f1;
        int f2;
        logic prev;
        do_reset();
        c = 0;
        while (spi.spi_chipselect === 1'b1 && c < 20) begin
            @(negedge clock);
            c++;
        end
        n_checks++;
        if (c !== 4) begin
            n_errors++;
            $display("FAIL cs_idle got %0d want 4", c);
        end
        n_checks++;
        if (spi.spi_clock !== 1'b1) begin
            n_errors++;
            $display("FAIL select sclk got %b want 1", spi.spi_clock);
        end
        d = 0;
        falls = 0;
        f1 = 0;
        f2 = 0;
        prev = spi.spi_clock;
        while (spi.spi_chipselect === 1'b0 && d < 200) begin
            @(negedge clock);
            d++;
            if (prev === 1'b1 && spi.spi_clock === 1'b0) begin
                falls++;
                if (falls == 1) f1 = d;
                if (falls == 2) f2 = d;
            end
            prev = spi.spi_clock;
        end
        n_checks++;
        if (d !== 68) begin
            n_errors++;
            $display("FAIL cs_low got %0d want 68", d);
        end
        n_checks++;
        if (falls !== 16) begin
            n_errors++;
            $display("FAIL pulses got %0d want 16", falls);
        end
        n_checks++;
        if (f2 - f1 !== 4) begin
            n_errors++;
            $display("FAIL sclk_period got %0d want 4", f2 - f1);
        end
        e = 0;
        while (spi.spi_chipselect === 1'b1 && e < 20) begin
            @(negedge clock);
            e++;
        end
        n_checks++;
        if (d + e !== 72) begin
            n_errors++;
            $display("FAIL frame_period got %0d want 72", d + e);
        end
    endtask

    task automatic test_capture();
        bit got;
        do_reset();
        push(16'hA5C3, 1);
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (dut.sample_valid === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_errors++;
            $display("FAIL capture valid got timeout want pulse");
        end
        n_checks++;
        if (dut.shift_reg !== 16'hA5C3) begin
            n_errors++;
            $display("FAIL capture got %h want a5c3", dut.shift_reg);
        end
    endtask

    task automatic test_quiet_window();
        int sv;
        int rdy;
        int sv_at;
        do_reset();
        push(16'h0100, 16);
        sv = 0;
        rdy = 0;
        sv_at = -1;
        for (int c = 0; c < 16 * 72 + 300; c++) begin
            @(negedge clock);
            if (dut.sample_valid === 1'b1) sv++;
            if (dut.energy_ready_sig === 1'b1) begin
                rdy++;
                sv_at = sv;
                n_checks++;
                if (dut.energy_reg !== 36'h0_0010_0000) begin
                    n_errors++;
                    $display("FAIL quiet energy got %h want 100000",
                             dut.energy_reg);
                end
            end
        end
        n_checks++;
        if (rdy !== 1 || sv_at !== 16) begin
            n_errors++;
            $display("FAIL quiet ready got %0d@%0d want 1@16", rdy, sv_at);
        end
        n_checks++;
        if (toglite_state !== 1'b0) begin
            n_errors++;
            $display("FAIL quiet light got %b want 0", toglite_state);
        end
    endtask

    task automatic test_clap_sequence();
        do_reset();
        push(16'h4000, 16);
        push(16'h0000, 48);
        push(16'h4000, 16);
        push(16'h0000, 16);
        push(16'h4000, 16);
        push(16'h0000, 320);
        push(16'h4000, 16);
        push(16'h0000, 48);
        push(16'h4000, 16);
        step_windows(5, "pair");
        n_checks++;
        if (toglite_state !== 1'b1) begin
            n_errors++;
            $display("FAIL pair light got %b want 1", toglite_state);
        end
        step_windows(22, "expire");
        n_checks++;
        if (toglite_state !== 1'b1) begin
            n_errors++;
            $display("FAIL expire light got %b want 1", toglite_state);
        end
        step_windows(5, "again");
        n_checks++;
        if (toglite_state !== 1'b0) begin
            n_errors++;
            $display("FAIL again light got %b want 0", toglite_state);
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        push(16'h8000, 16);
        step_windows(1, "fullscale");
        n_checks++;
        if (dut.energy_reg !== 36'h4_0000_0000) begin
            n_errors++;
            $display("FAIL fullscale energy got %h want 400000000",
                     dut.energy_reg);
        end
    endtask

    task automatic test_threshold_boundary();
        do_reset();
        push(16'h8000, 1);
        push(16'h0000, 15);
        push(16'h7FFF, 1);
        push(16'h0000, 15);
        push(16'h8000, 1);
        push(16'h0000, 15);
        step_windows(3, "thresh");
        n_checks++;
        if (toglite_state !== 1'b1) begin
            n_errors++;
            $display("FAIL thresh light got %b want 1", toglite_state);
        end
    endtask

    task automatic test_reset_midframe();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clock);
            if (spi.spi_chipselect === 1'b0 && spi.spi_clock === 1'b0)
                got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_errors++;
            $display("FAIL midframe reach got timeout want shift");
        end
        #2;
        nreset = 1'b0;
        #1;
        n_checks++;
        if (spi.spi_chipselect !== 1'b1 || spi.spi_clock !== 1'b1) begin
            n_errors++;
            $display("FAIL midframe cs/sclk got %b%b want 11",
                     spi.spi_chipselect, spi.spi_clock);
        end
        n_checks++;
        if (toglite_state !== 1'b0) begin
            n_errors++;
            $display("FAIL midframe light got %b want 0", toglite_state);
        end
        @(negedge clock);
        nreset = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] v;
        int kind;
        do_reset();
        for (int w = 0; w < 16; w++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                if (kind <= 1) v = 16'($urandom_range(0, 255));
                else if (kind == 2) v = 16'($urandom_range(16'h4000, 16'h7FFF));
                else v = 16'($urandom());
                if ($urandom_range(0, 1) == 1) v = -v;
                push(v, 1);
            end
        end
        step_windows(16, "random");
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_capture();
        test_quiet_window();
        test_clap_sequence();
        test_full_scale();
        test_threshold_boundary();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
